seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD-to-7-segment decoder between NUM_DIGITS display digits.
- Holds the displayed value in a frame register.
- Accepts new values through a valid/ready write port; a new value takes effect only at a frame boundary, so a frame never mixes old and new digits.
- Each cycle it presents one digit's BCD code and a blank request to the shared decoder, and drives a one-hot digit-select.
- Sits between the application logic and the decoder plus display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DWELL_CYCLES, 1000, clock cycles each digit is lit (>=1).
- GAP_CYCLES, 2, blanked dead-time cycles after each digit to stop ghosting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- disp_on  in  1  1 = scanning enabled; 0 = display dark.
- wr_valid  in  1  write request.
- wr_data  in  4*NUM_DIGITS  packed BCD; digit 0 occupies bits [3:0].
- wr_ready  out  1  pending buffer can accept a write.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high.
- bcd_out  out  4  BCD code sent to the shared decoder.
- blank  out  1  decoder blank request; 1 forces all segments off.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=OFF, dig_sel=0, bcd_out=0, blank=1, frame_done=0, wr_ready=1.
  - frame register and pending buffer cleared to 0.
  - Digit index and dwell counter cleared.
  - Reset asserted mid-scan aborts the scan immediately; no frame_done pulse is produced.
- Write path:
  - Single-entry pending buffer. A write is accepted when wr_valid & wr_ready.
  - wr_ready = ~pending_full.
  - The frame register loads from pending at each frame start (entry to SHOW with index 0). The buffer frees the same cycle, so wr_ready rises the next cycle.
  - In OFF with pending_full, the load happens on the OFF->SHOW transition.
- FSM states: OFF, SHOW, GAP.
  - OFF: dig_sel=0, blank=1. Goes to SHOW (index 0) when disp_on=1.
  - SHOW:
    - dig_sel = one-hot(index).
    - bcd_out = frame[index].
    - blank=0, unless the digit is >9, in which case blank=1 (the decoder output is undefined for codes >9).
    - Stays for exactly DWELL_CYCLES cycles, then goes to GAP.
  - GAP:
    - dig_sel=0, blank=1, bcd_out holds its last value.
    - Stays for GAP_CYCLES cycles.
    - If index = NUM_DIGITS-1: index wraps to 0, frame_done pulses in the last GAP cycle, and the FSM goes to SHOW.
    - Otherwise index increments and the FSM goes to SHOW.
- disp_on=0 sampled in any state: next state is OFF, outputs dark the next cycle, index resets to 0. Pending writes remain held.
- Digit ordering and timing:
  - Scan order is 0..NUM_DIGITS-1.
  - Frame period = NUM_DIGITS*(DWELL_CYCLES+GAP_CYCLES) cycles.
  - Latency from disp_on rising to the first lit digit is 1 cycle.
- Write accepted in the same cycle the buffer drains at a frame start: the drain to the frame register happens first. The new write is not accepted, since wr_ready was 0 that cycle; it is accepted in a later cycle.
- All outputs are registered.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW, a digit is blanked (blank=1) if it and every higher-index digit are 0.
  - Digit 0 is never blanked by this rule.
  - Example: value 0042 displays as "  42".
  - Timing and dig_sel are unchanged.
- Undefined: zeros are displayed normally. Only the >9 rule blanks a digit.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum {OFF, SHOW, GAP}.
  - BCD_W=4 and BCD_MAX=9 constants.
  - A function that computes dwell/gap counter width from the parameters.
- Sub-module seg_scan_timer: loadable down-counter issuing a terminal-count pulse; it is reused for both dwell and gap.
- The BCD-to-7-segment decoder stays outside this block and is instantiated alongside it by the parent.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=1):
- Reset, then disp_on=1 with wr_data=16'h1234 written during OFF:
  - dig_sel cycles 0001/0010/0100/1000, 4 cycles each, each followed by 1 cycle of 0000.
  - bcd_out = 4,3,2,1.
  - frame_done pulses every 20 cycles.
- Write 16'h5678 mid-frame:
  - The current frame keeps showing 1234.
  - The next frame shows 8,7,6,5.
  - wr_ready is 0 from acceptance until that frame start.
- Two back-to-back writes mid-frame: the second is stalled (wr_ready=0) and is accepted only after the frame boundary.
- wr_data=16'h9A01: digit 2 (A) is shown with blank=1 and dig_sel=0100; the other digits have blank=0.
- disp_on dropped mid-digit-2: next cycle dig_sel=0, blank=1. On re-enable, the scan restarts at digit 0.
- rst_n=0 during SHOW: outputs return to reset values the next cycle, with no frame_done pulse.
- With LEADING_ZERO_BLANK_EN, wr_data=16'h0040: digits 3 and 2 are blanked; digits 1 and 0 show 4 and 0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } seg_state_e;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Width of the shared dwell/gap down-counter; it must hold max(dwell, gap) - 1.
  function automatic int cnt_width(input int dwell, input int gap);
    int m;
    m = (dwell > gap) ? dwell : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Write port of the scan controller: single valid/ready transfer of a packed BCD value.
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                        wr_valid;
  logic [BCD_W*NUM_DIGITS-1:0] wr_data;
  logic                        wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// Loadable down-counter with terminal-count flags, shared by the dwell and gap phases.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] cnt_r;

  // Count register: load wins over counting, counting parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // tc_next looks one cycle ahead so the parent can register outputs on it.
  always_comb begin
    tc = (cnt_r == {W{1'b0}});
    if (load) begin
      tc_next = (load_val == {W{1'b0}});
    end else if (en) begin
      tc_next = (cnt_r <= W'(1));
    end else begin
      tc_next = tc;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller feeding one shared BCD-to-7-segment decoder.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_on,
  seg_scan_ctrl_if.slave        wr,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [BCD_W-1:0]      bcd_out,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CNT_W = cnt_width(DWELL_CYCLES, GAP_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FRM_W = BCD_W * NUM_DIGITS;
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  seg_state_e            state_r;
  seg_state_e            state_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [FRM_W-1:0]      frame_r;
  logic [FRM_W-1:0]      pend_r;
  logic [FRM_W-1:0]      frame_src_s;
  logic                  pend_full_r;
  logic                  wr_ready_r;
  logic                  frame_load_s;
  logic                  tmr_load_s;
  logic                  tmr_en_s;
  logic                  tmr_tc_s;
  logic                  tmr_tc_next_s;
  logic [CNT_W-1:0]      tmr_val_s;
  logic [BCD_W-1:0]      digit_s;
  logic                  digit_blank_s;
  logic [NUM_DIGITS-1:0] lz_s;

  assign wr.wr_ready = wr_ready_r;

  seg_scan_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .tc       (tmr_tc_s),
    .tc_next  (tmr_tc_next_s)
  );

  // Next-state, digit index and timer control decode.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    tmr_load_s   = 1'b0;
    tmr_val_s    = {CNT_W{1'b0}};
    tmr_en_s     = 1'b0;
    frame_load_s = 1'b0;
    case (state_r)
      OFF: begin
        if (disp_on) begin
          state_nxt_s  = SHOW;
          idx_nxt_s    = {IDX_W{1'b0}};
          tmr_load_s   = 1'b1;
          tmr_val_s    = DWELL_LD;
          frame_load_s = pend_full_r;
        end else begin
          state_nxt_s  = OFF;
        end
      end
      SHOW: begin
        if (!disp_on) begin
          state_nxt_s = OFF;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else if (tmr_tc_s) begin
          state_nxt_s = GAP;
          tmr_load_s  = 1'b1;
          tmr_val_s   = GAP_LD;
        end else begin
          tmr_en_s    = 1'b1;
        end
      end
      GAP: begin
        if (!disp_on) begin
          state_nxt_s = OFF;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else if (tmr_tc_s) begin
          state_nxt_s = SHOW;
          tmr_load_s  = 1'b1;
          tmr_val_s   = DWELL_LD;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s    = {IDX_W{1'b0}};
            frame_load_s = pend_full_r;
          end else begin
            idx_nxt_s    = idx_r + IDX_W'(1);
          end
        end else begin
          tmr_en_s    = 1'b1;
        end
      end
      default: begin
        state_nxt_s = OFF;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run_s;

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    lz_s     = {NUM_DIGITS{1'b0}};
    lz_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run_s = lz_run_s & (frame_src_s[i*BCD_W +: BCD_W] == {BCD_W{1'b0}});
      lz_s[i]  = lz_run_s;
    end
  end
`else
  // Leading zeros are displayed normally.
  always_comb begin
    lz_s = {NUM_DIGITS{1'b0}};
  end
`endif

  // Digit about to be shown; a frame starting this cycle already sees the pending value.
  always_comb begin
    frame_src_s = frame_load_s ? pend_r : frame_r;
    digit_s     = {BCD_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_s = (idx_nxt_s == IDX_W'(i)) ? frame_src_s[i*BCD_W +: BCD_W] : digit_s;
    end
    digit_blank_s = (digit_s > BCD_MAX) | lz_s[idx_nxt_s];
  end

  // FSM state, write buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= OFF;
      idx_r       <= {IDX_W{1'b0}};
      frame_r     <= {FRM_W{1'b0}};
      pend_r      <= {FRM_W{1'b0}};
      pend_full_r <= 1'b0;
      wr_ready_r  <= 1'b1;
      dig_sel     <= {NUM_DIGITS{1'b0}};
      bcd_out     <= {BCD_W{1'b0}};
      blank       <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (frame_load_s) begin
        frame_r     <= pend_r;
        pend_full_r <= 1'b0;
        wr_ready_r  <= 1'b1;
      end else if (wr.wr_valid && wr_ready_r) begin
        pend_r      <= wr.wr_data;
        pend_full_r <= 1'b1;
        wr_ready_r  <= 1'b0;
      end else begin
        pend_r      <= pend_r;
        pend_full_r <= pend_full_r;
        wr_ready_r  <= wr_ready_r;
      end
      frame_done <= (state_nxt_s == GAP) && tmr_tc_next_s && (idx_nxt_s == LAST_IDX);
      case (state_nxt_s)
        SHOW: begin
          dig_sel <= NUM_DIGITS'(1) << idx_nxt_s;
          bcd_out <= digit_s;
          blank   <= digit_blank_s;
        end
        GAP, OFF: begin
          dig_sel <= {NUM_DIGITS{1'b0}};
          bcd_out <= bcd_out;
          blank   <= 1'b1;
        end
        default: begin
          dig_sel <= {NUM_DIGITS{1'b0}};
          bcd_out <= bcd_out;
          blank   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed steps plus random traffic, checked every cycle
// against a model that derives the display from the elapsed scan position.
module tb_seg_scan_ctrl;

  localparam int N      = 4;
  localparam int D      = 4;
  localparam int G      = 1;
  localparam int SLOT   = D + G;
  localparam int PERIOD = N * SLOT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         disp_on;
  logic [N-1:0] dig_sel;
  logic [3:0]   bcd_out;
  logic         blank;
  logic         frame_done;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) wr_if ();

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_on    (disp_on),
    .wr         (wr_if),
    .dig_sel    (dig_sel),
    .bcd_out    (bcd_out),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  // Reference model: scanning flag, cycles since scan start, frame and pending values.
  bit             m_on = 1'b0;
  int             m_p = 0;
  int             m_dig = 0;
  int             m_slot = 0;
  logic [4*N-1:0] m_frame = '0;
  logic [4*N-1:0] m_pend = '0;
  bit             m_pend_full = 1'b0;
  logic [3:0]     m_bcd = 4'h0;
  logic [N-1:0]   e_sel = '0;
  bit             e_blank = 1'b1;
  bit             e_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rn, input logic on, input logic v, input logic [4*N-1:0] d);
    bit accept;
    if (!rn) begin
      m_on = 1'b0; m_p = 0; m_frame = '0; m_pend = '0; m_pend_full = 1'b0; m_bcd = 4'h0;
    end else begin
      accept = v && !m_pend_full;
      if (!on) m_on = 1'b0;
      else if (!m_on) begin m_on = 1'b1; m_p = 0; end
      else m_p = m_p + 1;
      if (m_on && (m_p % PERIOD == 0) && m_pend_full) begin
        m_frame = m_pend; m_pend_full = 1'b0;
      end else if (accept) begin
        m_pend = d; m_pend_full = 1'b1; n_acc++;
      end
    end
    m_slot = m_p % SLOT;
    m_dig  = (m_p / SLOT) % N;
    e_sel  = '0;
    if (m_on && m_slot < D) begin
      e_sel[m_dig] = 1'b1;
      m_bcd   = m_frame[m_dig*4 +: 4];
      e_blank = (m_bcd > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_dig != 0 && (m_frame >> (4*m_dig)) == '0) e_blank = 1'b1;
`endif
    end else begin
      e_blank = 1'b1;
    end
    e_done = m_on && (m_slot == SLOT - 1) && (m_dig == N - 1);
  endtask

  task automatic step(input logic rn, input logic on, input logic v, input logic [4*N-1:0] d);
    rst_n = rn; disp_on = on; wr_if.wr_valid = v; wr_if.wr_data = d;
    @(posedge clk);
    model_edge(rn, on, v, d);
    #1;
    chk("dig_sel",    32'(dig_sel),        32'(e_sel));
    chk("bcd_out",    32'(bcd_out),        32'(m_bcd));
    chk("blank",      32'(blank),          32'(e_blank));
    chk("frame_done", 32'(frame_done),     32'(e_done));
    chk("wr_ready",   32'(wr_if.wr_ready), 32'(!m_pend_full));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic send(input logic [4*N-1:0] d);
    int  start;
    bit  done;
    start = n_acc;
    done  = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !done; i++) begin
      step(1'b1, 1'b1, 1'b1, d);
      done = (n_acc != start);
    end
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL send_timeout: observed accepted=%0d expected 1", done);
    end
  endtask

  initial begin
    rst_n = 1'b0; disp_on = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);

    // Value written while dark, then scanning enabled.
    step(1'b1, 1'b0, 1'b1, 16'h1234);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    run(2 * PERIOD + 3);

    // Mid-frame write followed by a stalled back-to-back write.
    run(4);
    send(16'h5678);
    send(16'($urandom));
    run(2 * PERIOD);

    // Out-of-range digit is blanked.
    send(16'h9A01);
    run(2 * PERIOD + 2);

    // Drop disp_on while digit 2 is lit, then re-enable.
    for (int i = 0; i < 2 * PERIOD && !(m_on && m_dig == 2 && m_slot == 1); i++) run(1);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    run(PERIOD + 3);

    // Reset in the middle of a lit digit.
    for (int i = 0; i < 2 * PERIOD && !(m_on && m_slot == 2); i++) run(1);
    step(1'b0, 1'b1, 1'b0, '0);
    send(16'h0040);
    run(2 * PERIOD + 1);

    // Random traffic, occasional dark periods and resets.
    for (int i = 0; i < 600; i++) begin
      logic           rn;
      logic           on;
      logic           v;
      logic [4*N-1:0] d;
      rn = ($urandom_range(0, 99) != 0);
      on = ($urandom_range(0, 24) != 0);
      v  = ($urandom_range(0, 3) == 0);
      d  = 16'($urandom);
      step(rn, on, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
